operand_forward_unit: RTL
=========================

Name: operand_forward_unit

Overview:
- Execute-side counterpart of the decode-stage dependency checker in the 8-bit MIPS pipeline.
- Consumes the decoder's forwarding selects (mux_sel_a/b), immediate controls, destination tag and memory controls.
- Builds the ALU operands from the register file or from the EX/MEM/WB result history, and carries results down a 3-stage result pipeline.
- Drives the register-file write port and the data-memory request.

Parameters:
- DW, 8, datapath width (operands, results, memory data)
- AW, 5, register address / destination tag width
- OPW, 5, opcode width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- mux_sel_a  in  2  A-source select: 00 rf, 01 EX, 10 MEM, 11 WB
- mux_sel_b  in  2  B-source select, same encoding
- imm_sel  in  1  1: operand B is imm
- imm  in  DW  zero-extended immediate from decode
- RW_dec  in  AW  destination register of the decoded instruction
- op_dec  in  OPW  decoded opcode
- mem_en_dec  in  1  decoded instruction is LD/ST
- mem_rw_dec  in  1  1 = store, 0 = load (valid when mem_en_dec=1)
- mem_mux_sel_dec  in  1  writeback takes memory data (load)
- rf_data_a  in  DW  register-file read data A
- rf_data_b  in  DW  register-file read data B
- alu_result  in  DW  combinational ALU output for the EX-stage instruction
- dm_rdata  in  DW  combinational data-memory read data for the MEM-stage instruction
- op_a  out  DW  registered ALU operand A
- op_b  out  DW  registered ALU operand B
- op_ex  out  OPW  registered opcode to ALU
- mem_en  out  1  data-memory enable (MEM stage)
- mem_rw  out  1  data-memory write strobe (MEM stage)
- mem_addr  out  DW  data-memory address = MEM-stage ALU result
- mem_wdata  out  DW  store data (MEM stage)
- wb_en  out  1  register-file write enable
- wb_addr  out  AW  register-file write address
- wb_data  out  DW  register-file write data

Behaviour:
- Stages:
  - ID->EX: selection is combinational in the cycle the decode outputs are valid; registered into op_a/op_b/op_ex.
  - EX: alu_result is valid.
  - MEM: ex_res, dest and control registers.
  - WB: wb_* registers.
- Source per select:
  - 00 = rf_data
  - 01 = alu_result (instruction one ahead)
  - 10 = MEM stage value: dm_rdata if that stage is a load, else ex_res
  - 11 = wb_data
- op_b: imm when imm_sel=1, regardless of mux_sel_b. Store data uses the mux_sel_b path even when imm_sel=1 and is carried in an EX-stage register, then to mem_wdata.
- Valid bits:
  - Each stage carries a valid bit; a stage holding op_dec=00000 with RW_dec=0 is a bubble (valid=0).
  - A select pointing at an invalid stage falls back to rf_data.
- MEM controls:
  - mem_en = MEM valid & mem_en.
  - mem_rw = mem_en & store.
  - A load or store never writes back on its memory access itself except a load (mem_mux_sel).
- WB:
  - wb_en = 1 for a valid non-store instruction with destination not 0.
  - wb_data = dm_rdata captured for loads, ex_res otherwise.
  - Writes to register 0 are suppressed.
- Latency: decode input -> op_a/op_b 1 cycle; -> mem_* 2 cycles; -> wb_* 3 cycles.
- Simultaneous hazards: decode priority is trusted (01 over 10 over 11). Both operands may select the same stage.
- Reset:
  - Reset low clears all stage registers, valid bits and outputs to 0 asynchronously.
  - In-flight instructions are discarded. No write or memory strobe is emitted on the first edge after release.

Optional Feature:
- FWD_CNT_EN
  - Defined: adds output fwd_cnt[7:0], counting operands sourced from a non-00 select on a valid stage, +2 if both operands forward. Saturates at 255; cleared by reset.
  - Undefined: port and counter absent; no other behaviour change.

Test Plan:
- RAW on EX: ADD r3 (alu_result=0x2A), next instruction has mux_sel_a=01 -> op_a=0x2A one cycle later, not rf_data_a.
- Load-use via MEM: LD r4, dm_rdata=0x5C during its MEM cycle, instruction two behind with mux_sel_b=10 -> op_b=0x5C; wb_data=0x5C, wb_addr=4 next cycle.
- WB select with imm: mux_sel_a=11, wb_data=0x11, imm_sel=1, imm=0x07 -> op_a=0x11, op_b=0x07, mux_sel_b ignored.
- Store: ST with rf_data_b=0x99, alu_result=0x40 -> two cycles later mem_en=1, mem_rw=1, mem_addr=0x40, mem_wdata=0x99; no wb_en.
- Bubble fallback: mux_sel_a=10 while MEM holds a bubble -> op_a=rf_data_a; write to r0 gives wb_en=0.
- Async reset mid-stream: reset low between edges -> all outputs 0 immediately; after release, first three edges show wb_en=0 and mem_en=0 until new instructions arrive. With FWD_CNT_EN, fwd_cnt returns to 0.

Source files
------------

// File: rtl/operand_forward_unit.sv
// ============================================================================
// Module   : operand_forward_unit
// Purpose  : Execute-side operand forwarding and EX/MEM/WB result pipeline for
//            the 8-bit MIPS core.
//            Optional macro FWD_CNT_EN adds the saturating fwd_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_forward_unit #(
    parameter int DW  = 8,
    parameter int AW  = 5,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     mux_sel_a,
    input  logic [1:0]     mux_sel_b,
    input  logic           imm_sel,
    input  logic [DW-1:0]  imm,
    input  logic [AW-1:0]  RW_dec,
    input  logic [OPW-1:0] op_dec,
    input  logic           mem_en_dec,
    input  logic           mem_rw_dec,
    input  logic           mem_mux_sel_dec,
    input  logic [DW-1:0]  rf_data_a,
    input  logic [DW-1:0]  rf_data_b,
    input  logic [DW-1:0]  alu_result,
    input  logic [DW-1:0]  dm_rdata,
    output logic [DW-1:0]  op_a,
    output logic [DW-1:0]  op_b,
    output logic [OPW-1:0] op_ex,
    output logic           mem_en,
    output logic           mem_rw,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           wb_en,
    output logic [AW-1:0]  wb_addr,
    output logic [DW-1:0]  wb_data
`ifdef FWD_CNT_EN
    ,
    output logic [7:0]     fwd_cnt
`endif
);

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_EX  = 2'b01;
    localparam logic [1:0] c_SEL_MEM = 2'b10;
    localparam logic [1:0] c_SEL_WB  = 2'b11;

    // EX stage
    logic           r_ex_valid;
    logic [DW-1:0]  r_op_a;
    logic [DW-1:0]  r_op_b;
    logic [OPW-1:0] r_op_ex;
    logic [AW-1:0]  r_ex_dest;
    logic           r_ex_mem_en;
    logic           r_ex_mem_rw;
    logic           r_ex_load;
    logic [DW-1:0]  r_ex_sdata;

    // MEM stage
    logic           r_mem_valid;
    logic [DW-1:0]  r_mem_res;
    logic [AW-1:0]  r_mem_dest;
    logic           r_mem_mem_en;
    logic           r_mem_mem_rw;
    logic           r_mem_load;
    logic [DW-1:0]  r_mem_wdata;

    // WB stage
    logic           r_wb_valid;
    logic           r_wb_en;
    logic [AW-1:0]  r_wb_addr;
    logic [DW-1:0]  r_wb_data;

    logic           w_dec_valid;
    logic [DW-1:0]  w_mem_fwd;
    logic [DW-1:0]  w_fwd_a;
    logic [DW-1:0]  w_fwd_b;
    logic           w_hit_a;
    logic           w_hit_b;
    logic           w_mem_store;
    logic           w_wb_en_next;

    assign w_dec_valid = (op_dec != '0) || (RW_dec != '0);
    assign w_mem_fwd   = r_mem_load ? dm_rdata : r_mem_res;
    assign w_mem_store = r_mem_mem_en & r_mem_mem_rw;

    // A select that names an empty stage quietly degrades to the register file.
    always_comb begin
        w_fwd_a = rf_data_a;
        w_hit_a = 1'b0;
        case (mux_sel_a)
            c_SEL_EX:  if (r_ex_valid)  begin w_fwd_a = alu_result; w_hit_a = 1'b1; end
            c_SEL_MEM: if (r_mem_valid) begin w_fwd_a = w_mem_fwd;  w_hit_a = 1'b1; end
            c_SEL_WB:  if (r_wb_valid)  begin w_fwd_a = r_wb_data;  w_hit_a = 1'b1; end
            default:   w_fwd_a = rf_data_a;
        endcase
    end

    always_comb begin
        w_fwd_b = rf_data_b;
        w_hit_b = 1'b0;
        case (mux_sel_b)
            c_SEL_EX:  if (r_ex_valid)  begin w_fwd_b = alu_result; w_hit_b = 1'b1; end
            c_SEL_MEM: if (r_mem_valid) begin w_fwd_b = w_mem_fwd;  w_hit_b = 1'b1; end
            c_SEL_WB:  if (r_wb_valid)  begin w_fwd_b = r_wb_data;  w_hit_b = 1'b1; end
            default:   w_fwd_b = rf_data_b;
        endcase
    end

    // Stores never write back; loads and ALU ops do unless targeting r0.
    assign w_wb_en_next = r_mem_valid & ~w_mem_store & (r_mem_dest != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid   <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ex      <= '0;
            r_ex_dest    <= '0;
            r_ex_mem_en  <= 1'b0;
            r_ex_mem_rw  <= 1'b0;
            r_ex_load    <= 1'b0;
            r_ex_sdata   <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_res    <= '0;
            r_mem_dest   <= '0;
            r_mem_mem_en <= 1'b0;
            r_mem_mem_rw <= 1'b0;
            r_mem_load   <= 1'b0;
            r_mem_wdata  <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_en      <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
        end else begin
            r_ex_valid   <= w_dec_valid;
            r_op_a       <= w_fwd_a;
            r_op_b       <= imm_sel ? imm : w_fwd_b;
            r_op_ex      <= op_dec;
            r_ex_dest    <= RW_dec;
            r_ex_mem_en  <= mem_en_dec;
            r_ex_mem_rw  <= mem_rw_dec;
            r_ex_load    <= mem_mux_sel_dec;
            r_ex_sdata   <= w_fwd_b;

            r_mem_valid  <= r_ex_valid;
            r_mem_res    <= alu_result;
            r_mem_dest   <= r_ex_dest;
            r_mem_mem_en <= r_ex_mem_en;
            r_mem_mem_rw <= r_ex_mem_rw;
            r_mem_load   <= r_ex_load;
            r_mem_wdata  <= r_ex_sdata;

            r_wb_valid   <= r_mem_valid;
            r_wb_en      <= w_wb_en_next;
            r_wb_addr    <= r_mem_dest;
            r_wb_data    <= w_mem_fwd;
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign op_ex     = r_op_ex;
    assign mem_en    = r_mem_valid & r_mem_mem_en;
    assign mem_rw    = mem_en & r_mem_mem_rw;
    assign mem_addr  = r_mem_res;
    assign mem_wdata = r_mem_wdata;
    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;

`ifdef FWD_CNT_EN
    logic [7:0] r_fwd_cnt;
    logic [1:0] w_fwd_inc;
    logic [8:0] w_fwd_sum;

    // An immediate B operand is not a forwarded operand even if mux_sel_b is set.
    assign w_fwd_inc = {1'b0, w_hit_a} + {1'b0, w_hit_b & ~imm_sel};
    assign w_fwd_sum = {1'b0, r_fwd_cnt} + {7'b0, w_fwd_inc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd_cnt <= '0;
        end else begin
            r_fwd_cnt <= w_fwd_sum[8] ? 8'hFF : w_fwd_sum[7:0];
        end
    end

    assign fwd_cnt = r_fwd_cnt;
`endif

endmodule

`default_nettype wire
